// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared opcodes, state encoding and constants for the fetch redirect controller.
`timescale 1ns/1ps
package fetch_redirect_ctrl_pkg;

  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Handshake/bus bundle between the fetch controller and its environment.
// FETCH_REDIRECT_CNT_EN adds the REDIR_CNT / JAL_CNT counter outputs.
`timescale 1ns/1ps
interface fetch_redirect_ctrl_if;
  logic        STALL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic        F_VALID;
  logic [31:0] F_PC;
  logic [31:0] F_IR;
  logic [31:0] TG_JAL;
  logic        E_REDIRECT;
  logic [31:0] E_TARG;
  logic        FLUSH;
  logic        MISALIGN;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] REDIR_CNT;
  logic [31:0] JAL_CNT;
`endif

  modport master (
`ifdef FETCH_REDIRECT_CNT_EN
    output REDIR_CNT, output JAL_CNT,
`endif
    input  STALL, IMEM_ACK, IMEM_RDATA, TG_JAL, E_REDIRECT, E_TARG,
    output IMEM_REQ, IMEM_ADDR, F_VALID, F_PC, F_IR, FLUSH, MISALIGN
  );

  modport slave (
`ifdef FETCH_REDIRECT_CNT_EN
    input  REDIR_CNT, input JAL_CNT,
`endif
    output STALL, IMEM_ACK, IMEM_RDATA, TG_JAL, E_REDIRECT, E_TARG,
    input  IMEM_REQ, IMEM_ADDR, F_VALID, F_PC, F_IR, FLUSH, MISALIGN
  );
endinterface

// File: rtl/fetch_redirect_ctrl_next_pc.sv
// Combinational next-PC mux: redirect > JAL > PC+4, with word alignment
// of selected targets and a misalignment flag.
`timescale 1ns/1ps
module fetch_next_pc
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic        redirect,
  input  logic [31:0] redirect_targ,
  input  logic        jal,
  input  logic [31:0] jal_targ,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc  = pc + PC_INC;
    misalign = 1'b0;
    if (redirect) begin
      next_pc  = word_align(redirect_targ);
      misalign = |redirect_targ[1:0];
    end else if (jal) begin
      next_pc  = word_align(jal_targ);
      misalign = |jal_targ[1:0];
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencer: single-outstanding IMEM requests, redirects, stale-response drain.
// FETCH_REDIRECT_CNT_EN enables saturating redirect / early-JAL counters.
`timescale 1ns/1ps
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input logic                   CLK,
  input logic                   RST,
  fetch_redirect_ctrl_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         req_q, req_d;
  logic         f_valid_q, f_valid_d;
  logic [31:0]  f_pc_q, f_pc_d;
  logic [31:0]  f_ir_q, f_ir_d;
  logic         flush_q, flush_d;
  logic         misalign_q, misalign_d;

  logic         jal_dec;
  logic [31:0]  npc;
  logic         npc_mis;

  assign jal_dec = (state_q == HOLD) && (f_ir_q[6:0] == OP_JAL);

  fetch_next_pc u_next_pc (
    .redirect      (bus.E_REDIRECT),
    .redirect_targ (bus.E_TARG),
    .jal           (jal_dec),
    .jal_targ      (bus.TG_JAL),
    .pc            (pc_q),
    .next_pc       (npc),
    .misalign      (npc_mis)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    req_d      = req_q;
    f_valid_d  = f_valid_q;
    f_pc_d     = f_pc_q;
    f_ir_d     = f_ir_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
        if (bus.E_REDIRECT) begin
          pc_d       = npc;
          flush_d    = 1'b1;
          misalign_d = npc_mis;
        end
      end
      FETCH: begin
        if (bus.E_REDIRECT) begin
          flush_d    = 1'b1;
          misalign_d = npc_mis;
          if (bus.IMEM_ACK) begin
            pc_d = npc;
          end else begin
            // The outstanding request cannot be withdrawn; park the target.
            pend_d  = npc;
            state_d = DRAIN;
          end
        end else if (bus.IMEM_ACK) begin
          f_ir_d    = bus.IMEM_RDATA;
          f_pc_d    = pc_q;
          f_valid_d = 1'b1;
          req_d     = 1'b0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (bus.E_REDIRECT || !bus.STALL) begin
          pc_d       = npc;
          misalign_d = npc_mis;
          flush_d    = bus.E_REDIRECT;
          f_valid_d  = 1'b0;
          req_d      = 1'b1;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (bus.E_REDIRECT) begin
          flush_d    = 1'b1;
          misalign_d = npc_mis;
          if (bus.IMEM_ACK) begin
            pc_d    = npc;
            state_d = FETCH;
          end else begin
            pend_d = npc;
          end
        end else if (bus.IMEM_ACK) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pend_q     <= 32'h0;
      req_q      <= 1'b0;
      f_valid_q  <= 1'b0;
      f_pc_q     <= 32'h0;
      f_ir_q     <= 32'h0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      f_valid_q  <= f_valid_d;
      f_pc_q     <= f_pc_d;
      f_ir_q     <= f_ir_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  // The request address is the PC itself; PC only moves when no request is live.
  assign bus.IMEM_REQ  = req_q;
  assign bus.IMEM_ADDR = pc_q;
  assign bus.F_VALID   = f_valid_q;
  assign bus.F_PC      = f_pc_q;
  assign bus.F_IR      = f_ir_q;
  assign bus.FLUSH     = flush_q;
  assign bus.MISALIGN  = misalign_q;

`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic [31:0] jal_cnt_q, jal_cnt_d;

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    jal_cnt_d   = jal_cnt_q;
    if (bus.E_REDIRECT && (redir_cnt_q != 32'hFFFF_FFFF))
      redir_cnt_d = redir_cnt_q + 32'd1;
    if (jal_dec && !bus.STALL && !bus.E_REDIRECT && (jal_cnt_q != 32'hFFFF_FFFF))
      jal_cnt_d = jal_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      redir_cnt_q <= 32'h0;
      jal_cnt_q   <= 32'h0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      jal_cnt_q   <= jal_cnt_d;
    end
  end

  assign bus.REDIR_CNT = redir_cnt_q;
  assign bus.JAL_CNT   = jal_cnt_q;
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the fetch stage: owns the architectural fetch PC and issues single-outstanding instruction-memory requests.
- Presents the fetched F_PC/F_IR pair to decode and to the target generator.
- Selects the next PC, highest priority first: execute-stage redirect (taken branch, JALR, mispredict), then fetch-stage early JAL target, then PC+4.
- Discards in-flight responses that a redirect has made stale.

Parameters:
- RESET_VEC, 32'h0000_0000, PC loaded on reset; first fetch address.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- STALL  in  1  decode cannot accept; hold F_* outputs
- IMEM_REQ  out  1  instruction-memory request, held until IMEM_ACK
- IMEM_ADDR  out  32  request address, stable while IMEM_REQ=1
- IMEM_ACK  in  1  response valid this cycle (one per request)
- IMEM_RDATA  in  32  instruction word, valid with IMEM_ACK
- F_VALID  out  1  F_PC/F_IR hold a live instruction
- F_PC  out  32  PC of presented instruction
- F_IR  out  32  presented instruction word
- TG_JAL  in  32  JAL target from target generator (F_PC + J-imm of F_IR)
- E_REDIRECT  in  1  execute-stage redirect, single-cycle pulse
- E_TARG  in  32  redirect target, valid with E_REDIRECT
- FLUSH  out  1  one-cycle pulse: kill younger instructions in decode
- MISALIGN  out  1  one-cycle pulse: selected target had bits[1:0] != 0

Behaviour:
- Reset (async assert): PC=RESET_VEC, state=BOOT, all outputs 0 except IMEM_ADDR=RESET_VEC. Pending-target register cleared.
- BOOT -> FETCH on first clock after RST deasserts; no request in BOOT.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
  - On IMEM_ACK: F_IR<=IMEM_RDATA, F_PC<=PC, F_VALID<=1, -> HOLD.
  - Ack latency is arbitrary (>=0 extra cycles); minimum fetch-to-present latency is 1 cycle after ack.
- HOLD: F_VALID=1, IMEM_REQ=0.
  - With STALL=1 and no redirect: remain, outputs frozen.
  - With STALL=0: PC <= (F_IR[6:0]==OP_JAL) ? TG_JAL : PC+4. F_VALID<=0, -> FETCH.
  - The JAL early redirect needs no flush, because only one request is outstanding.
- E_REDIRECT overrides everything, including STALL:
  - In HOLD or BOOT-exit: PC<=E_TARG, F_VALID<=0, FLUSH=1, -> FETCH.
  - In FETCH, same cycle as IMEM_ACK: response discarded (F_VALID stays 0), PC<=E_TARG, FLUSH=1, -> FETCH.
  - In FETCH, no ack: request cannot be cancelled. Latch pending target, FLUSH=1, -> DRAIN.
- DRAIN: IMEM_REQ stays 1 with the old address.
  - On IMEM_ACK: response dropped, PC<=pending target, -> FETCH.
  - A further E_REDIRECT in DRAIN overwrites the pending target (latest wins) and pulses FLUSH again.
  - E_REDIRECT coincident with the DRAIN ack: the new E_TARG wins.
- Target alignment: any selected target (E_TARG, TG_JAL) with bits[1:0]!=0 is loaded with bits[1:0] forced to 0. MISALIGN pulses in the cycle it is selected. PC+4 never misaligns.
- Arithmetic: PC+4 is 32-bit modular; 32'hFFFF_FFFC wraps to 0 with no flag.
- PC register only changes on transitions listed above. IMEM_ADDR never changes while IMEM_REQ=1.
- RST asserted mid-request: state returns to BOOT immediately. A late IMEM_ACK arriving in BOOT is ignored.

Optional Feature:
- Macro: FETCH_REDIRECT_CNT_EN.
- Defined: adds outputs REDIR_CNT[31:0] and JAL_CNT[31:0].
  - REDIR_CNT counts accepted E_REDIRECT pulses, including those overwritten in DRAIN.
  - JAL_CNT counts early JAL redirects taken from HOLD.
  - Both saturate at 32'hFFFF_FFFF and clear on RST.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared opcodes package:
  - OP_JAL = 7'b1101111.
  - State enum fetch_state_t {BOOT, FETCH, HOLD, DRAIN}.
  - Constant PC_INC = 32'd4.
- Sub-module: fetch_next_pc, combinational next-PC mux.
  - Inputs: redirect, JAL decode, PC+4 selection.
  - Performs alignment masking and generates MISALIGN.
- Counters stay inline under the macro.

Test Plan:
- Reset release, RESET_VEC=32'h100, ack 2 cycles after each req, STALL=0, IR=NOP: IMEM_ADDR sequence 0x100, 0x104, 0x108. F_VALID high one cycle per ack+1.
- F_IR=JAL (opcode 1101111), TG_JAL=32'h200: next IMEM_ADDR=0x200, FLUSH=0. JAL_CNT=1 with macro.
- E_REDIRECT to 0x400 while FETCH outstanding at 0x108, ack 3 cycles later with data 0xDEADBEEF: FLUSH pulses once. 0xDEADBEEF never appears with F_VALID=1. Next IMEM_ADDR=0x400.
- Two E_REDIRECTs in DRAIN (0x400 then 0x500), then ack: next IMEM_ADDR=0x500, FLUSH pulsed twice, REDIR_CNT=2.
- STALL=1 in HOLD for 5 cycles, then E_REDIRECT to 0x302: F_* frozen during stall. Redirect accepted despite STALL, F_VALID drops, MISALIGN=1, next IMEM_ADDR=0x300.
- PC=0xFFFF_FFFC sequential fetch: next IMEM_ADDR=0x0. RST asserted mid-FETCH: IMEM_REQ=0 immediately, restart at RESET_VEC.
